// File: rtl/spi_master_engine.sv
//------------------------------------------------------------------------------
// spi_master_engine
//
// SPI master shift engine placed between a TX byte FIFO and an RX byte FIFO.
// It pops one word, asserts chip-select and shifts the word out MSB-first on
// mosi while capturing miso. The received word is then pushed into the RX
// FIFO, or dropped with a pulse on rx_drop when that FIFO is full. Words are
// streamed back-to-back under one chip-select while the TX FIFO has data and
// enable stays high.
//
// Parameters:
//   DATA_WIDTH  bits per SPI word (>= 2)
//   CLK_DIV     clk cycles per SCLK half-period (>= 1)
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   enable            permits starting new words
//   cpol, cpha        SPI mode, latched when a word is popped
//   tx_empty, tx_data TX FIFO status / read data
//   tx_rd_en          one-cycle TX FIFO pop (combinational)
//   rx_full           RX FIFO full flag
//   rx_wr_en, rx_data one-cycle RX FIFO push and the received word
//   rx_drop           one-cycle pulse: received word discarded (RX full)
//   busy              engine is inside a frame
//   sclk, mosi, miso  SPI bus
//   cs_n              chip select, active-low
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module spi_master_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  tx_empty,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_rd_en,
  input  logic                  rx_full,
  output logic                  rx_wr_en,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_drop,
  output logic                  busy,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n
);

  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t                state, state_next;
  logic [DIV_W-1:0]      div_cnt;
  logic [EDGE_W-1:0]     edge_cnt;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] rx_shift_next;
  logic [DATA_WIDTH-1:0] rx_data_reg;
  logic                  cpol_lat, cpha_lat;
  logic                  sclk_reg, mosi_reg, cs_n_reg;

  logic                  div_last;
  logic                  pop;
  logic                  edge_fire;
  logic                  sample_edge;
  logic                  drive_edge;
  logic                  last_edge;
  logic                  hold_first;
  logic [EDGE_W-1:0]     edge_num;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and control decode
  always_comb begin
    state_next    = state;
    div_last      = (div_cnt == DIV_LAST);
    edge_num      = edge_cnt + EDGE_W'(1);
    last_edge     = (edge_num == EDGE_LAST);
    hold_first    = (state == HOLD) && (div_cnt == '0);
    // rst_n gates the pop so the FIFO is never read while the engine is held.
    pop           = rst_n && enable && !tx_empty &&
                    ((state == IDLE) || ((state == HOLD) && div_last));
    // An SCLK edge is produced when the divider wraps in SETUP (edge 1) or SHIFT.
    edge_fire     = div_last && ((state == SETUP) || (state == SHIFT));
    // Odd edges are leading: mode 0 samples on them, mode 1 samples on even ones.
    sample_edge   = edge_fire && (edge_num[0] ^ cpha_lat);
    // Mode 0 has no data change on the final trailing edge.
    drive_edge    = edge_fire && !sample_edge && (cpha_lat || !last_edge);
    rx_shift_next = rx_shift;
    if (sample_edge) rx_shift_next = {rx_shift[DATA_WIDTH-2:0], miso};

    unique case (state)
      IDLE:    if (pop) state_next = SETUP;
      SETUP:   if (div_last) state_next = SHIFT;
      SHIFT:   if (edge_fire && last_edge) state_next = HOLD;
      HOLD:    if (div_last) state_next = pop ? SETUP : IDLE;
      default: state_next = IDLE;
    endcase

    tx_rd_en = pop;
    busy     = (state != IDLE);
    rx_wr_en = hold_first && !rx_full;
    rx_drop  = hold_first && rx_full;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      edge_cnt    <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      rx_data_reg <= '0;
      cpol_lat    <= 1'b0;
      cpha_lat    <= 1'b0;
      sclk_reg    <= 1'b0;
      mosi_reg    <= 1'b0;
      cs_n_reg    <= 1'b1;
    end else begin
      div_cnt <= ((state == IDLE) || div_last) ? '0 : div_cnt + DIV_W'(1);

      if (pop)            edge_cnt <= '0;
      else if (edge_fire) edge_cnt <= edge_num;

      if (pop) begin
        cpol_lat <= cpol;
        cpha_lat <= cpha;
      end

      if (pop)             tx_shift <= tx_data;
      else if (drive_edge) tx_shift <= tx_shift << 1;

      // Mode 0 presents the MSB for the whole of SETUP; mode 1 keeps the old
      // level until edge 1. Leaving the frame returns mosi to 0.
      if (pop) begin
        if (!cpha) mosi_reg <= tx_data[DATA_WIDTH-1];
      end else if (drive_edge) begin
        mosi_reg <= cpha_lat ? tx_shift[DATA_WIDTH-1] : tx_shift[DATA_WIDTH-2];
      end else if ((state == HOLD) && div_last) begin
        mosi_reg <= 1'b0;
      end

      if (pop)            rx_shift <= '0;
      else                rx_shift <= rx_shift_next;

      if ((state == SHIFT) && edge_fire && last_edge) rx_data_reg <= rx_shift_next;

      // Idle SCLK tracks the cpol input; a pop loads the mode being latched.
      if ((state == IDLE) || pop) sclk_reg <= cpol;
      else if (edge_fire)         sclk_reg <= ~sclk_reg;
      else if (state == HOLD)     sclk_reg <= cpol_lat;

      if (pop)                            cs_n_reg <= 1'b0;
      else if ((state == HOLD) && div_last) cs_n_reg <= 1'b1;
    end
  end

  assign sclk    = sclk_reg;
  assign mosi    = mosi_reg;
  assign cs_n    = cs_n_reg;
  assign rx_data = rx_data_reg;

endmodule

// File: tb/tb_spi_master_engine.sv
`timescale 1ns/1ps

module tb_spi_master_engine;

  localparam int W     = 8;
  localparam int D     = 4;
  localparam int FRAME = 2 * W * D + D;   // pop cycle to last HOLD cycle

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    bit         drop;
    int         t0;
  } sb_t;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic         cpol;
  logic         cpha;
  logic         tx_empty;
  logic [W-1:0] tx_data;
  logic         tx_rd_en;
  logic         rx_full;
  logic         rx_wr_en;
  logic [W-1:0] rx_data;
  logic         rx_drop;
  logic         busy;
  logic         sclk;
  logic         mosi;
  logic         miso;
  logic         cs_n;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  logic [7:0] tx_q[$];
  logic [7:0] slave_q[$];
  sb_t        sb[$];
  int         last_t0  = -1000;
  int         prev_end = -1000;
  logic       cpol_f = 1'b0, cpha_f = 1'b0;
  logic       loopback = 1'b0;
  logic       slave_bit = 1'b0;
  logic [7:0] slave_word = '0, slave_cap = '0;
  int         ecount = 0;
  bit         pend = 0;

  assign miso = loopback ? mosi : slave_bit;

  spi_master_engine #(.DATA_WIDTH(W), .CLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cpol(cpol), .cpha(cpha),
    .tx_empty(tx_empty), .tx_data(tx_data), .tx_rd_en(tx_rd_en),
    .rx_full(rx_full), .rx_wr_en(rx_wr_en), .rx_data(rx_data), .rx_drop(rx_drop),
    .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  task automatic update_tx();
    tx_empty = (tx_q.size() == 0);
    tx_data  = (tx_q.size() != 0) ? tx_q[0] : '0;
  endtask

  task automatic push_tx(input logic [7:0] w);
    tx_q.push_back(w);
    update_tx();
  endtask

  // Bit the slave presents after ec SCLK edges of the current word.
  function automatic logic slave_out(input logic [7:0] w, input int ec, input logic ph);
    int idx;
    idx = ph ? ((ec == 0) ? 0 : (ec - 1) / 2) : ec / 2;
    if (idx > W - 1) idx = W - 1;
    return w[W-1-idx];
  endfunction

  // Reference model, slave and scoreboard monitor, all evaluated mid-cycle.
  initial begin
    logic [7:0] w, sw;
    logic       prev_sclk, prev_mosi, exp_pop, exp_low, in_win, edge_now;
    sb_t        e;
    int         k;
    prev_sclk = 1'b0;
    prev_mosi = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_sclk = sclk;
        prev_mosi = mosi;
      end else begin
        if (pend) begin
          w    = tx_q.pop_front();
          pend = 0;
          update_tx();
        end
        // A pop may happen whenever no frame is running or a frame is in its last cycle.
        exp_pop = enable && (tx_q.size() != 0) && (cyc >= last_t0 + FRAME);
        chk("tx_rd_en", tx_rd_en, exp_pop);
        if (tx_rd_en && tx_q.size() != 0) begin
          prev_end   = last_t0 + FRAME;
          last_t0    = cyc;
          cpol_f     = cpol;
          cpha_f     = cpha;
          w          = tx_q[0];
          sw         = (slave_q.size() != 0) ? slave_q.pop_front() : 8'($urandom);
          e.tx       = w;
          e.rx       = loopback ? w : sw;
          e.drop     = rx_full;
          e.t0       = cyc;
          sb.push_back(e);
          ecount     = 0;
          slave_cap  = '0;
          slave_word = sw;
          slave_bit  = slave_out(sw, 0, cpha);
          pend       = 1;
        end

        in_win  = (cyc > last_t0) && (cyc <= last_t0 + FRAME);
        exp_low = in_win || (cyc <= prev_end);
        chk("cs_n", cs_n, !exp_low);
        chk("busy", busy, exp_low);
        if (in_win) begin
          k = (cyc - last_t0 - 1) / D;
          if (k > 2 * W) k = 2 * W;
          chk("sclk", sclk, cpol_f ^ (k % 2 == 1));
        end
        if (cyc > last_t0 + FRAME) chk("mosi_idle", mosi, 1'b0);

        edge_now = !cs_n && (sclk != prev_sclk);
        if (edge_now) begin
          ecount++;
          if ((ecount % 2 == 1) != cpha_f) slave_cap = {slave_cap[6:0], mosi};
          slave_bit = slave_out(slave_word, ecount, cpha_f);
        end
        if (in_win && cpha_f && (mosi != prev_mosi))
          chk("mosi_on_lead", edge_now && (ecount % 2 == 1), 1'b1);
        prev_sclk = sclk;
        prev_mosi = mosi;

        if (rx_wr_en || rx_drop) begin
          if (sb.size() == 0) begin
            fail("unexpected_push");
          end else begin
            e = sb.pop_front();
            chk("push_cycle", cyc, e.t0 + 1 + 2 * W * D);
            chk("rx_drop", rx_drop, e.drop);
            chk("rx_wr_en", rx_wr_en, !e.drop);
            if (rx_wr_en) chk("rx_data", rx_data, e.rx);
            chk("mosi_word", slave_cap, e.tx);
            chk("sclk_edges", ecount, 2 * W);
            $display("txn t0=%0d tx=%02h rx=%02h exp_rx=%02h drop=%0d",
                     e.t0, e.tx, rx_data, e.rx, rx_drop);
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    enable = 1'b1;
    while (!(tx_q.size() == 0 && sb.size() == 0 && cyc > last_t0 + FRAME + 1) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 3000) fail("idle_timeout");
  endtask

  task automatic set_mode(input logic pl, input logic ph);
    cpol = pl;
    cpha = ph;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int n, t, nw;
    rst_n = 1'b0; enable = 1'b1; cpol = 1'b0; cpha = 1'b0; rx_full = 1'b0;
    tx_empty = 1'b1; tx_data = '0;
    push_tx(8'h77);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rx_wr_en", rx_wr_en, 1'b0);
    chk("rst_rx_drop", rx_drop, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_tx_rd_en", tx_rd_en, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    wait_idle();

    // Mode 0 loopback
    loopback = 1'b1;
    set_mode(1'b0, 1'b0);
    push_tx(8'hA5);
    wait_idle();

    // Mode 3 with a fixed slave word
    loopback = 1'b0;
    set_mode(1'b1, 1'b1);
    slave_q.push_back(8'hC3);
    push_tx(8'h3C);
    wait_idle();

    // Back-to-back words under one chip-select
    set_mode(1'b0, 1'b0);
    push_tx(8'h11);
    push_tx(8'h22);
    wait_idle();

    // RX FIFO full: word is dropped
    rx_full = 1'b1;
    push_tx(8'h5A);
    wait_idle();
    rx_full = 1'b0;

    // Reset after SCLK edge 6, then a clean frame
    push_tx(8'h96);
    n = 0;
    while (sb.size() == 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() == 0) fail("reset_test_no_pop");
    push_tx(8'h69);
    n = 0;
    while (cyc < last_t0 + 1 + 6 * D && n < 100) begin
      @(posedge clk);
      n++;
    end
    #2 rst_n = 1'b0;
    sb.delete();
    last_t0  = -1000;
    prev_end = -1000;
    ecount   = 0;
    #1;
    chk("midrst_cs_n", cs_n, 1'b1);
    chk("midrst_sclk", sclk, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_mosi", mosi, 1'b0);
    chk("midrst_rx_data", rx_data, 8'h00);
    chk("midrst_tx_rd_en", tx_rd_en, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_idle();

    // Pop gating by enable
    enable = 1'b0;
    push_tx(8'hE7);
    repeat (20) @(posedge clk);
    #1;
    enable = 1'b1;
    t = cyc;
    @(negedge clk);
    #1;
    chk("gate_pop_cycle", last_t0, t);
    wait_idle();

    // Randomised bursts
    for (int b = 0; b < 12; b++) begin
      wait_idle();
      set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      loopback = 1'($urandom_range(0, 1));
      rx_full  = ($urandom_range(0, 3) == 0);
      nw = $urandom_range(1, 3);
      for (int i = 0; i < nw; i++) push_tx(8'($urandom));
      for (int c = 0; c < nw * 70; c++) begin
        @(posedge clk);
        #1;
        // cpha is only latched at a pop, so mid-frame flips must have no effect.
        if ($urandom_range(0, 15) == 0) cpha = ~cpha;
        if ($urandom_range(0, 31) == 0) enable = ~enable;
      end
      enable = 1'b1;
    end
    wait_idle();
    rx_full = 1'b0;
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
